counter_arbiter_2req: RTL and testbench
=======================================

Name: counter_arbiter_2req

Overview:
Schedules one shared WIDTH-bit up-counter between two requesters, each of which asks for a timed interval of programmable length.
- Round-robin arbitration picks the next requester.
- Controller loads the granted interval length, runs the counter, pulses a per-requester done, then releases the counter.
- Sits between the counter register and the blocks needing delays or tick intervals.

Parameters:
WIDTH, 4, width of counter, length inputs and cnt output

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous reset, active-low (sampled on rising edge of clk)
req0  input  1  requester 0 wants an interval; level, held until done0 or abort
req1  input  1  requester 1 wants an interval
len0  input  WIDTH  interval length for requester 0, sampled only at grant
len1  input  WIDTH  interval length for requester 1, sampled only at grant
gnt0  output  1  counter owned by requester 0
gnt1  output  1  counter owned by requester 1
busy  output  1  high in any state other than IDLE
cnt  output  WIDTH  current shared counter value
done0  output  1  one-cycle pulse, requester 0 interval complete
done1  output  1  one-cycle pulse, requester 1 interval complete

Behaviour:
- Reset (rst==0 at an edge), regardless of state:
  - state=IDLE; gnt0=gnt1=busy=done0=done1=0; cnt=0; len_q=0.
  - Round-robin pointer favours requester 0 (last_gnt=1).
- FSM states: IDLE, COUNT, DONE; all outputs registered.
- IDLE:
  - Only req0 high -> grant 0. Only req1 high -> grant 1.
  - Both high -> grant the requester not granted last.
  - On the grant edge: gnt_x<=1, len_q<=len_x, cnt<=0, state<=COUNT.
  - No request -> stay IDLE, cnt holds 0.
- COUNT:
  - cnt!=len_q -> cnt<=cnt+1.
  - cnt==len_q -> done_x<=1, state<=DONE; cnt holds.
  - len_q=0 is legal: done on the first COUNT edge.
- DONE (exactly one cycle):
  - done_x<=0, gnt_x<=0, cnt<=0, last_gnt<=x, state<=IDLE.
- Timing:
  - Grant to done pulse: len+1 edges.
  - gnt_x is high for len+2 cycles.
  - At least one IDLE cycle between consecutive grants.
- Arithmetic: cnt is unsigned WIDTH bits and never wraps, since len_q <= 2^WIDTH-1.
- gnt0 and gnt1 are never high together. done_x is only ever high while gnt_x is high.
- Changes to len_x after the grant are ignored.
- Losing requester: its req stays pending and is served after the current grant completes.

Optional Feature:
Macro: CTRL_ABORT_EN
- Defined: if the granted requester drops req_x while in COUNT, the next edge goes to IDLE.
  - gnt_x<=0, cnt<=0, no done pulse.
  - last_gnt<=x, so an abort counts as a served turn.
- Not defined: req_x dropping during COUNT is ignored; the interval runs to completion and done_x still pulses.
- Dropping req in DONE has no effect in either build.

Test Plan:
- Reset: hold rst=0 for 2 edges with req0=1 -> gnt0=0, busy=0, cnt=0, done0=0. Release rst -> gnt0=1 on the next edge.
- Single request: req0=1, len0=3 -> cnt 0,1,2,3; done0 pulses 4 edges after grant; gnt0 high 5 cycles; then busy=0.
- Contention: req0=req1=1 held, len0=2, len1=1 from reset.
  - Grant order is 0,1,0,1.
  - done0 and done1 alternate; gnt0 and gnt1 are never both high.
- Zero length: req1=1, len1=0 -> done1 pulses on the edge after grant; gnt1 high 2 cycles.
- Abort: req0=1, len0=9; drop req0 when cnt=4.
  - With CTRL_ABORT_EN: next edge gnt0=0, cnt=0, no done0.
  - Without: cnt reaches 9 and done0 pulses.
- Mid-operation reset: req1=1, len1=7; assert rst at cnt=5 -> next edge all outputs 0. After release with req0=req1=1, gnt0 is granted first.

Source files
------------

// File: rtl/counter_arbiter_2req.sv
// Shares one WIDTH-bit up-counter between two requesters using round-robin grants.
// Optional build macro CTRL_ABORT_EN: dropping the granted request while counting aborts the interval.
module counter_arbiter_2req #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] len0,
  input  logic [WIDTH-1:0] len1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             busy,
  output logic [WIDTH-1:0] cnt,
  output logic             done0,
  output logic             done1
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] COUNT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] len_q;
  logic             last_gnt;
  logic             pick1;

  // Requester 1 wins when it is alone, or when both ask and 0 was served last.
  assign pick1 = req1 && (!req0 || !last_gnt);

`ifdef CTRL_ABORT_EN
  logic owner_req;
  assign owner_req = gnt1 ? req1 : req0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
      busy     <= 1'b0;
      done0    <= 1'b0;
      done1    <= 1'b0;
      cnt      <= '0;
      len_q    <= '0;
      last_gnt <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (req0 || req1) begin
            gnt0  <= !pick1;
            gnt1  <= pick1;
            len_q <= pick1 ? len1 : len0;
            busy  <= 1'b1;
            state <= COUNT;
          end
        end
        COUNT: begin
`ifdef CTRL_ABORT_EN
          // An abort still counts as a served turn for round-robin purposes.
          if (!owner_req) begin
            gnt0     <= 1'b0;
            gnt1     <= 1'b0;
            busy     <= 1'b0;
            cnt      <= '0;
            last_gnt <= gnt1;
            state    <= IDLE;
          end else
`endif
          if (cnt != len_q) begin
            cnt <= cnt + WIDTH'(1);
          end else begin
            done0 <= gnt0;
            done1 <= gnt1;
            state <= DONE;
          end
        end
        DONE: begin
          done0    <= 1'b0;
          done1    <= 1'b0;
          gnt0     <= 1'b0;
          gnt1     <= 1'b0;
          busy     <= 1'b0;
          cnt      <= '0;
          last_gnt <= gnt1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_counter_arbiter_2req.sv
// Scoreboard bench for counter_arbiter_2req: stimulus queues expected intervals, a monitor checks done pulses.
// Abort expectations follow the CTRL_ABORT_EN build macro.
module tb_counter_arbiter_2req;

  localparam int WIDTH = 4;

  logic             clk;
  logic             rst;
  logic             req0;
  logic             req1;
  logic [WIDTH-1:0] len0;
  logic [WIDTH-1:0] len1;
  logic             gnt0;
  logic             gnt1;
  logic             busy;
  logic [WIDTH-1:0] cnt;
  logic             done0;
  logic             done1;

  typedef struct {
    int id;
    int len;
  } exp_t;

  exp_t expq[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  counter_arbiter_2req #(.WIDTH(WIDTH)) dut (
    .clk  (clk),
    .rst  (rst),
    .req0 (req0),
    .req1 (req1),
    .len0 (len0),
    .len1 (len1),
    .gnt0 (gnt0),
    .gnt1 (gnt1),
    .busy (busy),
    .cnt  (cnt),
    .done0(done0),
    .done1(done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks = checks + 1;
    if (actual !== expected) begin
      errors = errors + 1;
      $display("[TB] FAIL %s actual=%0d expected=%0d at cycle %0d", name, actual, expected, cyc);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic q0, input logic q1,
                               input int l0, input int l1);
    rst  = r;
    req0 = q0;
    req1 = q1;
    len0 = WIDTH'(l0);
    len1 = WIDTH'(l1);
  endtask

  task automatic pushExp(input int id, input int len);
    exp_t e;
    e.id  = id;
    e.len = len;
    expq.push_back(e);
  endtask

  task automatic waitDone(input int which, input int limit);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!((which == 0 && done0) || (which == 1 && done1) ||
                 (which == 2 && (done0 || done1))) && n < limit);
    if (n >= limit) checkOutput("done_timeout", 0, 1);
  endtask

  task automatic waitCnt(input int value, input int limit);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (int'(cnt) != value && n < limit);
    if (n >= limit) checkOutput("cnt_timeout", 0, 1);
  endtask

  // Monitor: checks every done pulse against the queue, plus latency and grant duration
  int   start_cyc = 0;
  int   cur_len   = 0;
  bit   had_done  = 0;
  logic prev0     = 0;
  logic prev1     = 0;

  always @(negedge clk) begin
    exp_t e;
    if (gnt0 || gnt1) checkOutput("gnt_exclusive", int'(gnt0 && gnt1), 0);
    if ((gnt0 && !prev0) || (gnt1 && !prev1)) begin
      start_cyc = cyc;
      had_done  = 0;
    end
    if (done0 || done1) begin
      if (expq.size() == 0) begin
        checkOutput("unexpected_done", 1, 0);
      end else begin
        e = expq.pop_front();
        checkOutput("done_id", done1 ? 1 : 0, e.id);
        checkOutput("done_gnt", done1 ? int'(gnt1) : int'(gnt0), 1);
        checkOutput("done_cnt", int'(cnt), e.len);
        checkOutput("done_latency", cyc - start_cyc, e.len + 1);
        cur_len  = e.len;
        had_done = 1;
      end
    end
    if (((!gnt0 && prev0) || (!gnt1 && prev1)) && had_done) begin
      checkOutput("gnt_duration", cyc - start_cyc, cur_len + 2);
      had_done = 0;
    end
    prev0 = gnt0;
    prev1 = gnt1;
  end

  initial begin
    applyStimulus(1'b0, 1'b1, 1'b0, 3, 0);

    // Reset held with a pending request
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    checkOutput("reset_gnt0", int'(gnt0), 0);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_cnt", int'(cnt), 0);
    checkOutput("reset_done0", int'(done0), 0);

    // Single request, len changed after grant must be ignored
    pushExp(0, 3);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("first_grant_gnt0", int'(gnt0), 1);
    checkOutput("first_grant_busy", int'(busy), 1);
    len0 = 4'd7;
    waitDone(0, 20);
    req0 = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("single_idle_busy", int'(busy), 0);

    // Contention from reset: order 0,1,0,1
    applyStimulus(1'b0, 1'b1, 1'b1, 2, 1);
    @(negedge clk);
    pushExp(0, 2);
    pushExp(1, 1);
    pushExp(0, 2);
    pushExp(1, 1);
    rst = 1'b1;
    for (int k = 0; k < 4; k++) waitDone(2, 20);
    req0 = 1'b0;
    req1 = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("contention_drained", expq.size(), 0);

    // Zero-length interval
    pushExp(1, 0);
    applyStimulus(1'b1, 1'b0, 1'b1, 0, 0);
    waitDone(1, 20);
    req1 = 1'b0;
    repeat (3) @(negedge clk);

    // Request dropped while counting
`ifndef CTRL_ABORT_EN
    pushExp(0, 9);
`endif
    applyStimulus(1'b1, 1'b1, 1'b0, 9, 0);
    waitCnt(4, 20);
    req0 = 1'b0;
`ifdef CTRL_ABORT_EN
    @(negedge clk);
    checkOutput("abort_gnt0", int'(gnt0), 0);
    checkOutput("abort_cnt", int'(cnt), 0);
    checkOutput("abort_done0", int'(done0), 0);
`else
    waitDone(0, 20);
    checkOutput("noabort_cnt", int'(cnt), 9);
`endif
    repeat (3) @(negedge clk);

    // Mid-operation reset, then contention must restart with requester 0
    applyStimulus(1'b1, 1'b0, 1'b1, 0, 7);
    waitCnt(5, 20);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midreset_gnt1", int'(gnt1), 0);
    checkOutput("midreset_busy", int'(busy), 0);
    checkOutput("midreset_cnt", int'(cnt), 0);
    checkOutput("midreset_done1", int'(done1), 0);
    pushExp(0, 1);
    pushExp(1, 2);
    applyStimulus(1'b1, 1'b1, 1'b1, 1, 2);
    @(negedge clk);
    checkOutput("postreset_gnt0", int'(gnt0), 1);
    checkOutput("postreset_gnt1", int'(gnt1), 0);
    waitDone(2, 20);
    waitDone(2, 20);
    req0 = 1'b0;
    req1 = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("final_queue_empty", expq.size(), 0);
    checkOutput("final_busy", int'(busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
